axi_ram_slave: RTL

AXI3 responder backed by an on-chip word memory: accepts read and write bursts from the uncached/cached data-side AXI initiators and returns R/B responses. It serves as the slave-side model and simulation target behind the AXI crossbar for data-path bring-up. Independent read and write FSMs with one outstanding transaction each; INCR bursts only, 32-bit beats only.

---
 rtl/axi_ram_slave.sv | 328 ++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_ram_slave.sv
// axi_ram_slave: AXI3 responder backed by an on-chip 32-bit word memory.
// Independent read and write engines, one outstanding transaction each,
// INCR bursts of up to 16 beats, 32-bit beats only.
// Optional build macro: AXI_SLV_STALL_EN inserts LFSR-driven ready stalls
// on arready/awready/wready (rvalid/bvalid are never stalled).
// INIT_ZERO records whether the simulator clears the array at time zero; the
// array itself carries no initializer and is never touched by reset.
module axi_ram_slave #(
    parameter int DEPTH_WORDS = 1024,
    parameter int INIT_ZERO   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam int          AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] DEPTH_L = 32'(DEPTH_WORDS);
    localparam logic [1:0]  OKAY    = 2'b00;
    localparam logic [1:0]  SLVERR  = 2'b10;

    typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} rd_state_e;
    typedef enum logic [1:0] {W_IDLE = 2'b00, W_DATA = 2'b01, W_RESP = 2'b10} wr_state_e;

    // read engine state
    rd_state_e   rd_state_q, rd_state_d;
    logic [3:0]  rid_q, rid_d;
    logic [29:0] raddr_q, raddr_d;
    logic [3:0]  rlen_q, rlen_d;
    logic [3:0]  rcnt_q, rcnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;
    logic        rlast_q, rlast_d;
    logic        rvalid_q, rvalid_d;
    logic        arready_q, arready_d;

    // write engine state
    wr_state_e   wr_state_q, wr_state_d;
    logic [3:0]  bid_q, bid_d;
    logic [29:0] waddr_q, waddr_d;
    logic [3:0]  wlen_q, wlen_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic        wover_q, wover_d;
    logic        werr_q, werr_d;
    logic [1:0]  bresp_q, bresp_d;
    logic        bvalid_q, bvalid_d;
    logic        awready_q, awready_d;
    logic        wready_q, wready_d;

    // memory ports
    logic [31:0] mem_q [DEPTH_WORDS];
    logic [29:0] mem_rd_addr_s;
    logic [31:0] mem_rd_data_s;
    logic        rd_in_range_s;
    logic        wr_in_range_s;
    logic        mem_we_s;

    logic stall_s;
    logic ar_hs_s, r_hs_s, aw_hs_s, w_hs_s, b_hs_s;
    logic unused_s;

`ifdef AXI_SLV_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;

    // Fibonacci LFSR (taps 16,14,13,11) shifted every cycle.
    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    // LFSR register, reseeded on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign stall_s = (lfsr_q[1:0] == 2'b11);
`else
    assign stall_s = 1'b0;
`endif

    assign arready = arready_q & ~stall_s;
    assign awready = awready_q & ~stall_s;
    assign wready  = wready_q & ~stall_s;
    assign rid     = rid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign rlast   = rlast_q;
    assign rvalid  = rvalid_q;
    assign bid     = bid_q;
    assign bresp   = bresp_q;
    assign bvalid  = bvalid_q;

    assign ar_hs_s = arvalid & arready;
    assign r_hs_s  = rvalid_q & rready;
    assign aw_hs_s = awvalid & awready;
    assign w_hs_s  = wvalid & wready;
    assign b_hs_s  = bvalid_q & bready;

    // Address LSBs, upper length bits and the init flag carry no logic.
    assign unused_s = ^{araddr[1:0], awaddr[1:0], arlen[7:4], awlen[7:4], (INIT_ZERO != 0)};

    // Single read port: idle uses the incoming AR address, otherwise the burst pointer.
    assign mem_rd_addr_s = (rd_state_q == R_IDLE) ? araddr[31:2] : raddr_q;
    assign rd_in_range_s = ({2'b00, mem_rd_addr_s} < DEPTH_L);
    assign wr_in_range_s = ({2'b00, waddr_q} < DEPTH_L);
    assign mem_rd_data_s = mem_q[mem_rd_addr_s[AW-1:0]];

    // Byte-enabled write port; a same-cycle read still sees the old word.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) begin
                    mem_q[waddr_q[AW-1:0]][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Read engine next-state: load a beat on AR and on every non-last R handshake.
    always_comb begin
        rd_state_d = rd_state_q;
        rid_d      = rid_q;
        raddr_d    = raddr_q;
        rlen_d     = rlen_q;
        rcnt_d     = rcnt_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        rlast_d    = rlast_q;
        rvalid_d   = rvalid_q;
        arready_d  = arready_q;
        case (rd_state_q)
            R_IDLE: begin
                if (ar_hs_s) begin
                    rd_state_d = R_DATA;
                    rid_d      = arid;
                    raddr_d    = araddr[31:2] + 30'd1;
                    rlen_d     = arlen[3:0];
                    rcnt_d     = 4'd0;
                    rdata_d    = rd_in_range_s ? mem_rd_data_s : 32'd0;
                    rresp_d    = rd_in_range_s ? OKAY : SLVERR;
                    rlast_d    = (arlen[3:0] == 4'd0);
                    rvalid_d   = 1'b1;
                    arready_d  = 1'b0;
                end else begin
                    rd_state_d = R_IDLE;
                end
            end
            R_DATA: begin
                if (r_hs_s && rlast_q) begin
                    rd_state_d = R_IDLE;
                    rvalid_d   = 1'b0;
                    rlast_d    = 1'b0;
                    arready_d  = 1'b1;
                end else if (r_hs_s) begin
                    raddr_d = raddr_q + 30'd1;
                    rcnt_d  = rcnt_q + 4'd1;
                    rdata_d = rd_in_range_s ? mem_rd_data_s : 32'd0;
                    rresp_d = rd_in_range_s ? OKAY : SLVERR;
                    rlast_d = ((rcnt_q + 4'd1) == rlen_q);
                end else begin
                    rd_state_d = R_DATA;
                end
            end
            default: begin
                rd_state_d = R_IDLE;
                rvalid_d   = 1'b0;
                rlast_d    = 1'b0;
                arready_d  = 1'b1;
            end
        endcase
    end

    // Write engine next-state: commit beats, track length/range errors, issue B.
    always_comb begin
        wr_state_d = wr_state_q;
        bid_d      = bid_q;
        waddr_d    = waddr_q;
        wlen_d     = wlen_q;
        wcnt_d     = wcnt_q;
        wover_d    = wover_q;
        werr_d     = werr_q;
        bresp_d    = bresp_q;
        bvalid_d   = bvalid_q;
        awready_d  = awready_q;
        wready_d   = wready_q;
        mem_we_s   = 1'b0;
        case (wr_state_q)
            W_IDLE: begin
                if (aw_hs_s) begin
                    wr_state_d = W_DATA;
                    bid_d      = awid;
                    waddr_d    = awaddr[31:2];
                    wlen_d     = awlen[3:0];
                    wcnt_d     = 4'd0;
                    wover_d    = 1'b0;
                    werr_d     = 1'b0;
                    awready_d  = 1'b0;
                    wready_d   = 1'b1;
                end else begin
                    wr_state_d = W_IDLE;
                end
            end
            W_DATA: begin
                if (w_hs_s) begin
                    // beats past the announced length or past the array are dropped
                    mem_we_s = ~wover_q & wr_in_range_s;
                    waddr_d  = waddr_q + 30'd1;
                    werr_d   = werr_q | wover_q | ~wr_in_range_s;
                    if (wcnt_q == wlen_q) begin
                        wover_d = 1'b1;
                    end else begin
                        wcnt_d = wcnt_q + 4'd1;
                    end
                    if (wlast) begin
                        wr_state_d = W_RESP;
                        wready_d   = 1'b0;
                        bvalid_d   = 1'b1;
                        bresp_d    = (werr_q | wover_q | ~wr_in_range_s | (wcnt_q != wlen_q))
                                     ? SLVERR : OKAY;
                    end else begin
                        wr_state_d = W_DATA;
                    end
                end else begin
                    wr_state_d = W_DATA;
                end
            end
            W_RESP: begin
                if (b_hs_s) begin
                    wr_state_d = W_IDLE;
                    bvalid_d   = 1'b0;
                    awready_d  = 1'b1;
                end else begin
                    wr_state_d = W_RESP;
                end
            end
            default: begin
                wr_state_d = W_IDLE;
                bvalid_d   = 1'b0;
                wready_d   = 1'b0;
                awready_d  = 1'b1;
            end
        endcase
    end

    // Read engine registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_state_q <= R_IDLE;
            rid_q      <= 4'd0;
            raddr_q    <= 30'd0;
            rlen_q     <= 4'd0;
            rcnt_q     <= 4'd0;
            rdata_q    <= 32'd0;
            rresp_q    <= 2'b00;
            rlast_q    <= 1'b0;
            rvalid_q   <= 1'b0;
            arready_q  <= 1'b1;
        end else begin
            rd_state_q <= rd_state_d;
            rid_q      <= rid_d;
            raddr_q    <= raddr_d;
            rlen_q     <= rlen_d;
            rcnt_q     <= rcnt_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            rlast_q    <= rlast_d;
            rvalid_q   <= rvalid_d;
            arready_q  <= arready_d;
        end
    end

    // Write engine registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_state_q <= W_IDLE;
            bid_q      <= 4'd0;
            waddr_q    <= 30'd0;
            wlen_q     <= 4'd0;
            wcnt_q     <= 4'd0;
            wover_q    <= 1'b0;
            werr_q     <= 1'b0;
            bresp_q    <= 2'b00;
            bvalid_q   <= 1'b0;
            awready_q  <= 1'b1;
            wready_q   <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            bid_q      <= bid_d;
            waddr_q    <= waddr_d;
            wlen_q     <= wlen_d;
            wcnt_q     <= wcnt_d;
            wover_q    <= wover_d;
            werr_q     <= werr_d;
            bresp_q    <= bresp_d;
            bvalid_q   <= bvalid_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
        end
    end

endmodule
